// File: rtl/layer_out_serializer_if.sv
// Packed result bus between a fully-connected layer and its output serializer.
// The argmax ports exist only when SER_ARGMAX_EN is defined.
interface layer_out_serializer_if #(
    parameter int unsigned NN        = 30,
    parameter int unsigned dataWidth = 16
);
    localparam int unsigned CNT_W = (NN > 1) ? $clog2(NN) : 1;

    logic [NN-1:0]           i_valid;
    logic [NN*dataWidth-1:0] i_data;
    logic [dataWidth-1:0]    o_data;
    logic                    o_valid;
    logic                    o_busy;
    logic                    o_overrun;
`ifdef SER_ARGMAX_EN
    logic [CNT_W-1:0]        o_max_idx;
    logic [dataWidth-1:0]    o_max_val;
    logic                    o_max_valid;

    modport master (
        output i_valid, i_data,
        input  o_data, o_valid, o_busy, o_overrun, o_max_idx, o_max_val, o_max_valid
    );
    modport slave (
        input  i_valid, i_data,
        output o_data, o_valid, o_busy, o_overrun, o_max_idx, o_max_val, o_max_valid
    );
`else
    modport master (
        output i_valid, i_data,
        input  o_data, o_valid, o_busy, o_overrun
    );
    modport slave (
        input  i_valid, i_data,
        output o_data, o_valid, o_busy, o_overrun
    );
`endif
endinterface

// File: rtl/layer_out_serializer.sv
// Serializes a layer's parallel neuron results into one word per cycle for the next layer.
// Optional running argmax of each stream when SER_ARGMAX_EN is defined.
module layer_out_serializer #(
    parameter int unsigned  NN        = 30,
    parameter int unsigned  dataWidth = 16,
    localparam int unsigned CNT_W     = (NN > 1) ? $clog2(NN) : 1
) (
    input logic                   clk,
    input logic                   rst,
    layer_out_serializer_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NN - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [dataWidth-1:0] words_q [NN];
    logic [dataWidth-1:0] words_d [NN];
    logic [dataWidth-1:0] o_data_q, o_data_d;
    logic                 o_valid_q, o_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 trigger, last, capture;
    logic                 unused_valid;

    // All neurons fire together, so only bit 0 qualifies the vector.
    assign trigger      = bus.i_valid[0];
    assign unused_valid = ^bus.i_valid;
    assign last         = (cnt_q == LastIdx);
    assign cnt_inc      = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        words_d   = words_q;
        o_data_d  = '0;
        o_valid_d = 1'b0;
        overrun_d = overrun_q;
        capture   = 1'b0;
        case (state_q)
            StIdle: capture = trigger;
            StShift: begin
                if (last) begin
                    capture = trigger;
                    if (!trigger) state_d = StIdle;
                end else begin
                    overrun_d = overrun_q | trigger;
                    cnt_d     = cnt_inc;
                    o_data_d  = words_q[cnt_inc];
                    o_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Word 0 goes straight to the output register so it appears the cycle after capture.
        if (capture) begin
            state_d   = StShift;
            cnt_d     = '0;
            o_data_d  = bus.i_data[dataWidth-1:0];
            o_valid_d = 1'b1;
            for (int k = 0; k < int'(NN); k++) begin
                words_d[k] = bus.i_data[k*dataWidth +: dataWidth];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            words_q   <= '{default: '0};
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            words_q   <= words_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.o_data    = o_data_q;
    assign bus.o_valid   = o_valid_q;
    assign bus.o_busy    = (state_q == StShift);
    assign bus.o_overrun = overrun_q;

`ifdef SER_ARGMAX_EN
    logic [dataWidth-1:0] run_val_q, run_val_d, max_val_q, max_val_d;
    logic [CNT_W-1:0]     run_idx_q, run_idx_d, max_idx_q, max_idx_d;
    logic                 max_valid_q, max_valid_d;

    always_comb begin
        run_val_d   = run_val_q;
        run_idx_d   = run_idx_q;
        max_val_d   = max_val_q;
        max_idx_d   = max_idx_q;
        max_valid_d = 1'b0;
        // Publish while the last word is on the output; the running max already includes it.
        if (state_q == StShift && last) begin
            max_val_d   = run_val_q;
            max_idx_d   = run_idx_q;
            max_valid_d = 1'b1;
        end
        if (o_valid_d) begin
            if (cnt_d == '0) begin
                run_val_d = o_data_d;
                run_idx_d = '0;
            end else if ($signed(o_data_d) > $signed(run_val_q)) begin
                run_val_d = o_data_d;
                run_idx_d = cnt_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_val_q   <= '0;
            run_idx_q   <= '0;
            max_val_q   <= '0;
            max_idx_q   <= '0;
            max_valid_q <= 1'b0;
        end else begin
            run_val_q   <= run_val_d;
            run_idx_q   <= run_idx_d;
            max_val_q   <= max_val_d;
            max_idx_q   <= max_idx_d;
            max_valid_q <= max_valid_d;
        end
    end

    assign bus.o_max_idx   = max_idx_q;
    assign bus.o_max_val   = max_val_q;
    assign bus.o_max_valid = max_valid_q;
`endif
endmodule

// File: tb/tb_layer_out_serializer.sv
// Self-checking bench for layer_out_serializer (NN=4, dataWidth=16), scheduled stimulus vs a
// stream-level reference model; argmax checks are built when SER_ARGMAX_EN is defined.
module tb_layer_out_serializer;
    localparam int NN   = 4;
    localparam int W    = 16;
    localparam int CW   = 2;
    localparam int MAXC = 320;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_out_serializer_if #(.NN(NN), .dataWidth(W)) bus ();
    layer_out_serializer #(.NN(NN), .dataWidth(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Per-cycle stimulus schedule: inputs of cycle t are sampled at the edge ending cycle t.
    logic [NN-1:0]   val_s [MAXC];
    logic [NN*W-1:0] dat_s [MAXC];
    logic            rst_s [MAXC];
    // {o_valid, o_busy, o_overrun, o_data}
    logic [W+2:0]    exp_o [MAXC];
    logic [W+2:0]    obs_o [MAXC];
`ifdef SER_ARGMAX_EN
    logic            exp_mv [MAXC];
    logic            obs_mv [MAXC];
    logic [CW-1:0]   exp_mi [MAXC];
    logic [CW-1:0]   obs_mi [MAXC];
    logic [W-1:0]    exp_mx [MAXC];
    logic [W-1:0]    obs_mx [MAXC];
`endif
    int n_checks = 0;
    int n_fail   = 0;

    task automatic clear_sched();
        for (int t = 0; t < MAXC; t++) begin
            val_s[t] = '0;
            dat_s[t] = '0;
            rst_s[t] = 1'b0;
        end
        rst_s[0] = 1'b1;
    endtask

    // Reference: a vector is accepted when no stream occupies the cycle, or on its last word.
    task automatic build_model(input int ncyc);
        int s_end = -1;
        int best;
        logic [W-1:0] wk, wb;
        for (int u = 0; u <= ncyc; u++) begin
            exp_o[u] = '0;
`ifdef SER_ARGMAX_EN
            exp_mv[u] = 1'b0; exp_mi[u] = '0; exp_mx[u] = '0;
`endif
        end
        for (int t = 0; t < ncyc; t++) begin
            if (rst_s[t]) begin
                for (int u = t + 1; u <= ncyc; u++) begin
                    exp_o[u] = '0;
`ifdef SER_ARGMAX_EN
                    exp_mv[u] = 1'b0; exp_mi[u] = '0; exp_mx[u] = '0;
`endif
                end
                s_end = -1;
            end else if (val_s[t][0]) begin
                if (t >= s_end) begin
                    best = 0;
                    for (int k = 0; k < NN; k++) begin
                        wk = dat_s[t][k*W +: W];
                        wb = dat_s[t][best*W +: W];
                        if ($signed(wk) > $signed(wb)) best = k;
                        if (t + 1 + k <= ncyc) begin
                            exp_o[t+1+k][W+2:W+1] = 2'b11;
                            exp_o[t+1+k][W-1:0]   = wk;
                        end
                    end
`ifdef SER_ARGMAX_EN
                    if (t + NN + 1 <= ncyc) exp_mv[t+NN+1] = 1'b1;
                    for (int u = t + NN + 1; u <= ncyc; u++) begin
                        exp_mi[u] = CW'(best);
                        exp_mx[u] = dat_s[t][best*W +: W];
                    end
`endif
                    s_end = t + NN;
                end else begin
                    for (int u = t + 1; u <= ncyc; u++) exp_o[u][W] = 1'b1;
                end
            end
        end
    endtask

    task automatic run(input int ncyc);
        for (int t = 0; t <= ncyc; t++) begin
            @(negedge clk);
            obs_o[t] = {bus.o_valid, bus.o_busy, bus.o_overrun, bus.o_data};
`ifdef SER_ARGMAX_EN
            obs_mv[t] = bus.o_max_valid;
            obs_mi[t] = bus.o_max_idx;
            obs_mx[t] = bus.o_max_val;
`endif
            rst         = (t < ncyc) ? rst_s[t] : 1'b0;
            bus.i_valid = (t < ncyc) ? val_s[t] : '0;
            bus.i_data  = (t < ncyc) ? dat_s[t] : '0;
        end
    endtask

    task automatic test_reset();
        clear_sched();
        rst_s[1] = 1'b1;
        build_model(6);
        run(6);
        for (int t = 1; t <= 6; t++) begin
            n_checks++;
            if (obs_o[t] !== exp_o[t] || obs_o[t] !== '0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %h, want %h", t, obs_o[t], exp_o[t]);
            end
        end
    endtask

    task automatic test_basic();
        clear_sched();
        val_s[2] = 4'hF;
        dat_s[2] = 64'h0044_0033_0022_0011;
        build_model(12);
        run(12);
        for (int t = 1; t <= 12; t++) begin
            n_checks++;
            if (obs_o[t] !== exp_o[t]) begin
                n_fail++;
                $display("FAIL basic cyc %0d: got {v,b,ovr,d}=%h, want %h", t, obs_o[t], exp_o[t]);
            end
        end
        n_checks++;
        if (obs_o[3] !== {3'b110, 16'h0011} || obs_o[6] !== {3'b110, 16'h0044}
            || obs_o[7] !== '0) begin
            n_fail++;
            $display("FAIL basic_edges: got %h/%h/%h, want 60011/60044/00000",
                     obs_o[3], obs_o[6], obs_o[7]);
        end
    endtask

    task automatic test_back_to_back();
        clear_sched();
        val_s[2] = 4'hF;
        dat_s[2] = 64'h0044_0033_0022_0011;
        val_s[6] = 4'hF;
        dat_s[6] = 64'h000D_000C_000B_000A;
        build_model(16);
        run(16);
        for (int t = 1; t <= 16; t++) begin
            n_checks++;
            if (obs_o[t] !== exp_o[t]) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %h, want %h", t, obs_o[t], exp_o[t]);
            end
        end
        n_checks++;
        if (obs_o[7] !== {3'b110, 16'h000A} || obs_o[10] !== {3'b110, 16'h000D}) begin
            n_fail++;
            $display("FAIL back_to_back_seam: got %h/%h, want 6000a/6000d", obs_o[7], obs_o[10]);
        end
    endtask

    task automatic test_overrun();
        clear_sched();
        val_s[2] = 4'hF;
        dat_s[2] = 64'h0044_0033_0022_0011;
        val_s[4] = 4'hF;
        dat_s[4] = 64'hDEAD_BEEF_CAFE_F00D;
        build_model(110);
        run(110);
        for (int t = 1; t <= 110; t++) begin
            n_checks++;
            if (obs_o[t] !== exp_o[t]) begin
                n_fail++;
                $display("FAIL overrun cyc %0d: got %h, want %h", t, obs_o[t], exp_o[t]);
            end
        end
        n_checks++;
        if (obs_o[4][W] !== 1'b0 || obs_o[5][W] !== 1'b1 || obs_o[110][W] !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b%b%b, want 011",
                     obs_o[4][W], obs_o[5][W], obs_o[110][W]);
        end
    endtask

    task automatic test_reset_mid();
        clear_sched();
        val_s[2] = 4'hF;
        dat_s[2] = 64'h0044_0033_0022_0011;
        rst_s[4] = 1'b1;
        val_s[4] = 4'hF;
        val_s[8] = 4'hF;
        dat_s[8] = 64'h5555_6666_7777_8888;
        build_model(16);
        run(16);
        for (int t = 1; t <= 16; t++) begin
            n_checks++;
            if (obs_o[t] !== exp_o[t]) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got %h, want %h", t, obs_o[t], exp_o[t]);
            end
        end
        n_checks++;
        if (obs_o[5] !== '0 || obs_o[9] !== {3'b110, 16'h8888}) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got %h/%h, want 00000/68888", obs_o[5], obs_o[9]);
        end
    endtask

    task automatic test_idle();
        clear_sched();
        for (int t = 1; t < 16; t++) begin
            val_s[t] = 4'hE;
            dat_s[t] = {$urandom, $urandom};
        end
        build_model(20);
        run(20);
        for (int t = 1; t <= 20; t++) begin
            n_checks++;
            if (obs_o[t] !== exp_o[t] || obs_o[t] !== '0) begin
                n_fail++;
                $display("FAIL idle cyc %0d: got %h, want 00000", t, obs_o[t]);
            end
        end
    endtask

`ifdef SER_ARGMAX_EN
    task automatic test_argmax();
        clear_sched();
        val_s[2]  = 4'hF;
        dat_s[2]  = 64'h0030_0030_0005_FFF0;
        val_s[10] = 4'hF;
        dat_s[10] = 64'h8000_8000_8000_8000;
        build_model(20);
        run(20);
        for (int t = 1; t <= 20; t++) begin
            n_checks++;
            if (obs_mv[t] !== exp_mv[t] || obs_mi[t] !== exp_mi[t] || obs_mx[t] !== exp_mx[t]) begin
                n_fail++;
                $display("FAIL argmax cyc %0d: got pulse=%b idx=%0d val=%h, want %b %0d %h", t,
                         obs_mv[t], obs_mi[t], obs_mx[t], exp_mv[t], exp_mi[t], exp_mx[t]);
            end
        end
        n_checks++;
        if (obs_mv[7] !== 1'b1 || obs_mi[7] !== 2'd2 || obs_mx[7] !== 16'h0030
            || obs_mv[15] !== 1'b1 || obs_mi[15] !== 2'd0 || obs_mx[15] !== 16'h8000) begin
            n_fail++;
            $display("FAIL argmax_fixed: got %b/%0d/%h and %b/%0d/%h, want 1/2/0030 and 1/0/8000",
                     obs_mv[7], obs_mi[7], obs_mx[7], obs_mv[15], obs_mi[15], obs_mx[15]);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] w;
        clear_sched();
        for (int t = 1; t < 240; t++) begin
            rst_s[t] = ($urandom_range(0, 59) == 0);
            val_s[t] = NN'($urandom);
            val_s[t][0] = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < NN; k++) begin
                case ($urandom_range(0, 3))
                    0:       w = 16'h8000;
                    1:       w = 16'h7FFF;
                    default: w = 16'($urandom);
                endcase
                dat_s[t][k*W +: W] = w;
            end
        end
        build_model(250);
        run(250);
        for (int t = 1; t <= 250; t++) begin
            n_checks++;
            if (obs_o[t] !== exp_o[t]) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h, want %h", t, obs_o[t], exp_o[t]);
            end
`ifdef SER_ARGMAX_EN
            n_checks++;
            if (obs_mv[t] !== exp_mv[t] || obs_mi[t] !== exp_mi[t] || obs_mx[t] !== exp_mx[t]) begin
                n_fail++;
                $display("FAIL random_argmax cyc %0d: got %b %0d %h, want %b %0d %h", t,
                         obs_mv[t], obs_mi[t], obs_mx[t], exp_mv[t], exp_mi[t], exp_mx[t]);
            end
`endif
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_valid = '0;
        bus.i_data  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_idle();
`ifdef SER_ARGMAX_EN
        test_argmax();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
Consumes the parallel output of a fully-connected layer (NN neuron results plus per-neuron valid flags). Streams the results one word per cycle into the next layer's serial input (x_in/x_valid).
Sits between layer N and layer N+1, and is the receiving end of the layer's packed output bus.
Handles back-to-back layer results without bubbles and flags results that arrive while a stream is still in progress.

Parameters:
NN, 30, number of neurons in the upstream layer and the number of words per stream
dataWidth, 16, width of each neuron result in bits, two's complement
CNT_W, $clog2(NN) (minimum 1), width of the internal index counter (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_valid  input  NN  per-neuron output valid from the upstream layer; only bit 0 is used as the capture trigger
i_data  input  NN*dataWidth  packed neuron results; word k is i_data[k*dataWidth +: dataWidth]
o_data  output  dataWidth  serial word to the next layer's x_in
o_valid  output  1  qualifies o_data; drives the next layer's x_valid
o_busy  output  1  high while a stream is in progress
o_overrun  output  1  sticky; set when a result vector is dropped
o_max_idx  output  CNT_W  index of the largest word (only with SER_ARGMAX_EN)
o_max_val  output  dataWidth  value of the largest word (only with SER_ARGMAX_EN)
o_max_valid  output  1  one-cycle pulse marking the argmax result (only with SER_ARGMAX_EN)

Behaviour:
- Clock and reset: one clock domain, clk; reset is synchronous and active-high on rst.
- Reset: all outputs 0, FSM in IDLE, counter 0, capture register 0.
- Trigger: i_valid[0]==1 in a cycle where capture is allowed. All NN neurons in a layer fire in the same cycle; bits 1..NN-1 of i_valid are ignored.
- FSM has two states, IDLE and SHIFT.
  - IDLE + trigger: latch all of i_data, set counter=0, go to SHIFT.
  - SHIFT: each cycle drive word[counter] with o_valid=1, then counter++.
  - SHIFT, counter==NN-1 with no trigger: go to IDLE.
  - SHIFT, counter==NN-1 with trigger: re-latch i_data, counter=0, stay in SHIFT (gapless back-to-back streams).
- Latency: trigger sampled at cycle T.
  - Word 0 (lowest slice) appears on o_data at T+1.
  - Word k appears at T+1+k; the last word appears at T+NN.
  - o_valid stays high continuously for exactly NN cycles.
- o_data is registered and forced to 0 whenever o_valid==0.
- o_busy = (state==SHIFT), registered, and coincident with o_valid.
- Overrun:
  - A trigger while in SHIFT with counter!=NN-1 is dropped.
  - The stream in progress is unaffected.
  - o_overrun goes to 1 in the next cycle and stays 1 until rst.
- NN==1: every cycle of SHIFT is a last-word cycle, so a trigger every cycle gives continuous o_valid and never sets o_overrun.
- Reset mid-stream: the stream is aborted immediately. Outputs read 0 in the cycle after rst is sampled, and no partial words resume afterwards.
- No arithmetic on the data path; words pass through bit-exact.

Optional Feature:
Macro: SER_ARGMAX_EN.
- With the macro defined:
  - A running max register and index register track the streamed words using a signed compare.
  - Word 0 initialises both registers.
  - A later word replaces the max only if it is strictly greater, so on a tie the lower index wins.
  - o_max_idx/o_max_val are updated and o_max_valid pulses for 1 cycle at T+NN+1, one cycle after the last word.
  - On a gapless back-to-back stream, the pulse for stream 1 coincides with word 0 of stream 2.
  - All three outputs reset to 0; o_max_idx/o_max_val hold between pulses.
  - Used on the final layer to produce the classification result.
- Without the macro: the three ports and the associated logic are absent.

Test Plan (bench uses NN=4, dataWidth=16):
- Basic stream: i_data words {0x0011,0x0022,0x0033,0x0044}, i_valid=4'hF for 1 cycle at T -> o_valid high T+1..T+4 with o_data 0x0011,0x0022,0x0033,0x0044; o_busy matches o_valid; o_overrun=0.
- Back-to-back: second trigger at T+4 with words {0xA,0xB,0xC,0xD} -> 8 consecutive valid cycles with no gap; o_overrun=0.
- Overrun: second trigger at T+2 -> first stream completes unchanged and the second vector is never output; o_overrun=1 from T+3 and still 1 after 100 idle cycles.
- Reset mid-stream: rst asserted at T+2 -> o_valid=0, o_data=0, o_overrun=0 from T+3; a new trigger afterwards streams normally from word 0.
- Argmax (SER_ARGMAX_EN): words {0xFFF0(-16), 0x0005, 0x0030, 0x0030} -> o_max_valid pulse at T+5 with o_max_idx=2, o_max_val=0x0030. Then all words = 0x8000 -> o_max_idx=0.
- Idle check: i_valid[3:1]=3'b111 with i_valid[0]=0 -> no stream starts and all outputs stay 0.
